// File: rtl/big_clk_stim_sequencer.sv
// Time-unit ("big clock") generator and stimulus-table sequencer.
// It emits a pulse every PERIOD cycles and steps clamped signed samples onto input_signal.
module big_clk_stim_sequencer #(
  parameter int unsigned PERIOD  = 22,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned SAT_MAX = 999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              posedge_big_clk,
  output logic [WIDTH-1:0]  input_signal,
  output logic [ADDR_W-1:0] step_idx,
  output logic              busy,
  output logic              done
);
  localparam int unsigned TICK_W = $clog2(PERIOD);
  localparam logic [TICK_W-1:0]       L_LAST_TICK = TICK_W'(PERIOD - 1);
  localparam logic [ADDR_W:0]         L_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]         L_ONE       = (ADDR_W + 1)'(1);
  localparam logic signed [WIDTH-1:0] L_MAX       = WIDTH'(SAT_MAX);
  localparam logic signed [WIDTH-1:0] L_MIN       = -L_MAX;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [TICK_W-1:0]  r_tick;
  logic [ADDR_W-1:0]  r_step;
  logic [ADDR_W:0]    r_num;
  logic               r_loop;
  logic [WIDTH-1:0]   r_sig;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_start_ok, w_unit_end, w_last;
  logic [ADDR_W-1:0]  w_step_inc;
  logic signed [WIDTH-1:0] w_wr_s, w_clamped;

  assign w_start_ok = start && !stop && (num_steps != '0) && (num_steps <= L_DEPTH);
  assign w_unit_end = (r_state == RUN) && (r_tick == L_LAST_TICK);
  assign w_last     = ({1'b0, r_step} == (r_num - L_ONE));
  assign w_step_inc = r_step + ADDR_W'(1);

  // stop in the same cycle suppresses the pulse, so the pulse is gated combinationally
  assign posedge_big_clk = w_unit_end && !stop;
  assign busy            = (r_state == RUN);
  assign done            = (r_state == FIN);
  assign input_signal    = r_sig;
  assign step_idx        = r_step;

  always_comb begin
    w_wr_s    = $signed(wr_data);
    w_clamped = w_wr_s;
    if (w_wr_s > L_MAX) begin
      w_clamped = L_MAX;
    end else if (w_wr_s < L_MIN) begin
      w_clamped = L_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && wr_en) begin
      r_mem[wr_addr] <= w_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = RUN;
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_unit_end && w_last && !r_loop) begin
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_step <= '0;
      r_num  <= '0;
      r_loop <= 1'b0;
      r_sig  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_num  <= num_steps;
            r_loop <= loop_en;
            r_tick <= '0;
            r_step <= '0;
            r_sig  <= r_mem[0];
          end
        end
        RUN: begin
          if (stop) begin
            r_tick <= '0;
            r_step <= '0;
            r_sig  <= '0;
          end else if (w_unit_end) begin
            r_tick <= '0;
            if (w_last) begin
              // wrap keeps driving table[0]; a finishing run clears the output for FIN
              r_step <= '0;
              r_sig  <= r_loop ? r_mem[0] : '0;
            end else begin
              r_step <= w_step_inc;
              r_sig  <= r_mem[w_step_inc];
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: begin
          r_tick <= '0;
          r_step <= '0;
          r_sig  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_big_clk_stim_sequencer.sv
// Self-checking bench for big_clk_stim_sequencer: table vectors, directed corner cases,
// randomized runs against a cycle-arithmetic reference model, plus a PERIOD=2 instance.
module tb_big_clk_stim_sequencer;
  localparam int P = 22;

  logic        clk, rst_n;
  logic        start, stop, loop_en, wr_en;
  logic [6:0]  num_steps;
  logic [5:0]  wr_addr;
  logic [10:0] wr_data;
  logic        pulse, busy, done;
  logic [10:0] sig;
  logic [5:0]  step;

  logic        start2, stop2, loop2, wr_en2;
  logic [6:0]  num2;
  logic [5:0]  wr_addr2;
  logic [10:0] wr_data2;
  logic        pulse2, busy2, done2;
  logic [10:0] sig2;
  logic [5:0]  step2;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl [64];

  typedef struct {
    int wdata;
    int exp;
  } vec_t;
  vec_t vec [9];

  big_clk_stim_sequencer #(.PERIOD(P), .DEPTH(64), .ADDR_W(6), .WIDTH(11), .SAT_MAX(999)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .num_steps(num_steps), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .posedge_big_clk(pulse), .input_signal(sig), .step_idx(step), .busy(busy), .done(done)
  );

  big_clk_stim_sequencer #(.PERIOD(2), .DEPTH(64), .ADDR_W(6), .WIDTH(11), .SAT_MAX(999)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .loop_en(loop2),
    .num_steps(num2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .posedge_big_clk(pulse2), .input_signal(sig2), .step_idx(step2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int clamp(input int d);
    if (d > 999) return 999;
    if (d < -999) return -999;
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eb, input int ed, input int ep,
                         input int es, input int ev);
    chk({tag, " busy"}, int'(busy), eb);
    chk({tag, " done"}, int'(done), ed);
    chk({tag, " pulse"}, int'(pulse), ep);
    chk({tag, " step"}, int'(step), es);
    chk({tag, " sig"}, int'($signed(sig)), ev);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = 11'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    mdl[a] = clamp(d);
  endtask

  // Cycle k counts edges after start is applied; expectations come from unit = (k-1)/P.
  task automatic run(input int n, input int lp, input int nc, input int sc);
    int u, e_step;
    string tag;
    num_steps = 7'(n); loop_en = lp[0]; start = 1'b1;
    for (int k = 1; k <= nc; k++) begin
      @(posedge clk); #1;
      start  = (k == 5);
      wr_en  = (k == 3);
      wr_addr = 6'($urandom_range(0, 8));
      wr_data = 11'($urandom_range(0, 2047));
      stop   = (k == sc);
      #1;
      tag = $sformatf("run n%0d l%0d k%0d", n, lp, k);
      u = (k - 1) / P;
      if (sc != 0 && k > sc) begin
        chk_all(tag, 0, 0, 0, 0, 0);
      end else if (lp == 0 && u >= n) begin
        chk_all(tag, 0, (k == n * P + 1) ? 1 : 0, 0, 0, 0);
      end else begin
        e_step = u % n;
        chk_all(tag, 1, 0, ((k % P) == 0 && k != sc) ? 1 : 0, e_step, mdl[e_step]);
      end
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int t2 [3];
    int n, lp, nc, sc, ep, ev;
    vec[0] = '{5, 5};       vec[1] = '{-3, -3};     vec[2] = '{999, 999};
    vec[3] = '{0, 0};       vec[4] = '{1023, 999};  vec[5] = '{-1024, -999};
    vec[6] = '{1000, 999};  vec[7] = '{-1000, -999}; vec[8] = '{-999, -999};

    rst_n = 1'b0; start = 0; stop = 0; loop_en = 0; num_steps = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    start2 = 0; stop2 = 0; loop2 = 0; num2 = '0; wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors: the expected stored value comes from the vector, not from clamp().
    for (int i = 0; i < 9; i++) begin
      wr(i, vec[i].wdata);
      mdl[i] = vec[i].exp;
    end
    run(9, 0, 9 * P + 3, 0);

    run(4, 0, 4 * P + 4, 0);        // basic run: pulses 22..88, done at 89
    run(2, 1, 5 * P + 2, 5 * P);    // loop wrap, stop on 5th pulse
    run(4, 0, 2 * P + 4, 2 * P);    // stop on 2nd pulse
    run(9, 0, 9 * P + 2, 0);        // table intact after writes attempted in RUN

    // Asynchronous reset mid-run.
    run(5, 0, 29, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all("async rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_all("after rst", 0, 0, 0, 0, 0);
    run(9, 0, 9 * P + 2, 0);

    // Illegal step counts are ignored.
    for (int j = 0; j < 2; j++) begin
      num_steps = (j == 0) ? 7'd0 : 7'd65;
      start = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        chk($sformatf("bad n%0d busy", j), int'(busy), 0);
      end
      start = 1'b0;
    end

    // start and stop together in IDLE: stop wins.
    num_steps = 7'd3; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", int'(busy), 0);

    // Randomized runs.
    repeat (6) begin
      for (int a = 0; a < 10; a++) wr(a, int'($urandom_range(0, 2047)) - 1024);
      n  = int'($urandom_range(1, 8));
      lp = int'($urandom_range(0, 1));
      if (lp != 0) begin
        nc = (n + 2) * P;
        sc = int'($urandom_range(P, nc - 1));
      end else begin
        nc = n * P + 3;
        sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, n * P)) : 0;
      end
      run(n, lp, nc, sc);
    end

    // PERIOD=2 instance, 3 steps.
    t2[0] = 7; t2[1] = -5; t2[2] = 300;
    for (int a = 0; a < 3; a++) begin
      wr_en2 = 1'b1; wr_addr2 = 6'(a); wr_data2 = 11'(t2[a]);
      @(posedge clk); #1;
    end
    wr_en2 = 1'b0;
    num2 = 7'd3; loop2 = 1'b0; start2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      #1;
      ep = ((k % 2) == 0 && k <= 6) ? 1 : 0;
      ev = (k <= 6) ? t2[(k - 1) / 2] : 0;
      chk($sformatf("p2 k%0d pulse", k), int'(pulse2), ep);
      chk($sformatf("p2 k%0d done", k), int'(done2), (k == 7) ? 1 : 0);
      chk($sformatf("p2 k%0d busy", k), int'(busy2), (k <= 6) ? 1 : 0);
      chk($sformatf("p2 k%0d sig", k), int'($signed(sig2)), ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
